// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the word at the current PC from instruction
// memory over a req/ack handshake and hands it to decode over valid/ready.
module instr_fetch_unit #(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] pc_addr,
  output logic                 pc_advance,
  output logic                 imem_req,
  output logic [BUS_WIDTH-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  input  logic                 imem_err,
  input  logic                 flush,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [BUS_WIDTH-1:0] instr_out,
  output logic [BUS_WIDTH-1:0] instr_pc,
  output logic                 fetch_fault,
  output logic [BUS_WIDTH-1:0] fetch_count
);

  localparam int unsigned TO_W = 16;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            drop;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            misaligned;

  assign timeout_hit = (to_cnt == TO_LAST);
  assign misaligned  = (pc_addr[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an ack always wins over a timeout in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = misaligned ? FAULT : REQ;
      REQ: begin
        if (imem_ack) begin
          if (drop || flush) state_nxt = IDLE;
          else if (imem_err) state_nxt = FAULT;
          else               state_nxt = HOLD;
        end else if (timeout_hit) begin
          state_nxt = FAULT;
        end
      end
      HOLD:  if (flush || instr_ready) state_nxt = IDLE;
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  // PC step strobe: only a real decode handshake that is not being flushed
  always_comb begin
    pc_advance = instr_valid & instr_ready & ~flush & (state == HOLD);
  end

  // Registered outputs, drop flag and request timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
      drop        <= 1'b0;
      to_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          imem_addr <= pc_addr;
          if (misaligned) begin
            fetch_fault <= 1'b1;
          end else begin
            imem_req <= 1'b1;
            to_cnt   <= '0;
          end
        end
        REQ: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            drop     <= 1'b0;
            if (!(drop || flush)) begin
              if (imem_err) begin
                fetch_fault <= 1'b1;
              end else begin
                instr_out   <= imem_rdata;
                instr_pc    <= imem_addr;
                instr_valid <= 1'b1;
              end
            end
          end else begin
            // A flushed request stays on the bus; its data is dropped on ack
            if (flush) drop <= 1'b1;
            if (timeout_hit) begin
              imem_req    <= 1'b0;
              fetch_fault <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        HOLD: begin
          if (flush) begin
            instr_valid <= 1'b0;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            fetch_count <= fetch_count + BUS_WIDTH'(1);
          end
        end
        FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_fault <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: vector table plus corner-case sequences,
// delivered instructions checked against a scoreboard queue.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic [31:0] rdata;
    int          rdy_dly;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[5];

  instr_fetch_unit #(.BUS_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every decode handshake pops the oldest expected instruction
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: delivered 0x%08h at 0x%08h with nothing expected", instr_out, instr_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", instr_out, e.instr);
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_pc_advance", 32'(pc_advance), 32'd1);
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1; flush = 1'b0; imem_ack = 1'b0; imem_err = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0; pc_addr = '0;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_fault", 32'(fetch_fault), 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_adv", 32'(pc_advance), 0);
    exp_count = '0;
    rst = 1'b0;
  endtask

  // From IDLE: issue the fetch, hold ack off for lat cycles, then ack with data
  task automatic start_fetch(input logic [31:0] pc, input int lat, input logic [31:0] data,
                             input logic push, input logic [31:0] e_instr, input logic [31:0] e_pc);
    pc_addr = pc;
    tick();
    chk("req_rise", 32'(imem_req), 1);
    chk("req_addr", imem_addr, pc);
    for (int k = 0; k < lat; k++) begin
      tick();
      chk("req_held", 32'(imem_req), 1);
      chk("addr_held", imem_addr, pc);
      chk("no_valid_wait", 32'(instr_valid), 0);
    end
    imem_ack = 1'b1; imem_rdata = data;
    if (push) sb.push_back('{instr: e_instr, pc: e_pc});
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    chk("valid_after_ack", 32'(instr_valid), 1);
    chk("req_drop_ack", 32'(imem_req), 0);
  endtask

  // In HOLD: keep ready low rdy_dly cycles, then complete the handshake
  task automatic deliver(input int rdy_dly, input logic [31:0] e_instr);
    for (int r = 0; r < rdy_dly; r++) begin
      instr_ready = 1'b0;
      #1;
      chk("adv_low_wait", 32'(pc_advance), 0);
      tick();
      chk("valid_hold", 32'(instr_valid), 1);
      chk("instr_stable", instr_out, e_instr);
    end
    instr_ready = 1'b1;
    #1;
    chk("adv_high", 32'(pc_advance), 1);
    exp_count = exp_count + 32'd1;
    tick();
    instr_ready = 1'b0;
    chk("valid_clear", 32'(instr_valid), 0);
    chk("count", fetch_count, exp_count);
  endtask

  initial begin
    vecs[0] = '{pc: 32'h0000_0000, lat: 0, rdata: 32'h0000_0013, rdy_dly: 0,
                exp_instr: 32'h0000_0013, exp_pc: 32'h0000_0000};
    vecs[1] = '{pc: 32'h0000_0100, lat: 4, rdata: 32'h00A0_0093, rdy_dly: 3,
                exp_instr: 32'h00A0_0093, exp_pc: 32'h0000_0100};
    vecs[2] = '{pc: 32'h0000_0204, lat: 1, rdata: 32'hCAFE_F00D, rdy_dly: 1,
                exp_instr: 32'hCAFE_F00D, exp_pc: 32'h0000_0204};
    vecs[3] = '{pc: 32'h0000_0008, lat: 2, rdata: 32'h1234_5678, rdy_dly: 0,
                exp_instr: 32'h1234_5678, exp_pc: 32'h0000_0008};
    vecs[4] = '{pc: 32'hFFFF_FFFC, lat: 7, rdata: 32'hFFFF_FFFF, rdy_dly: 2,
                exp_instr: 32'hFFFF_FFFF, exp_pc: 32'hFFFF_FFFC};

    reset_dut();
    for (int i = 0; i < 5; i++) begin
      start_fetch(vecs[i].pc, vecs[i].lat, vecs[i].rdata, 1'b1, vecs[i].exp_instr, vecs[i].exp_pc);
      deliver(vecs[i].rdy_dly, vecs[i].exp_instr);
    end

    // Flush two cycles before the ack: request held, data dropped
    pc_addr = 32'h0000_0300;
    tick();
    chk("fl_req", 32'(imem_req), 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req_held", 32'(imem_req), 1);
    chk("fl_addr_held", imem_addr, 32'h0000_0300);
    tick();
    chk("fl_req_held2", 32'(imem_req), 1);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    chk("fl_no_valid", 32'(instr_valid), 0);
    chk("fl_req_low", 32'(imem_req), 0);
    chk("fl_count", fetch_count, exp_count);
    start_fetch(32'h0000_0400, 0, 32'h0040_0513, 1'b1, 32'h0040_0513, 32'h0000_0400);
    deliver(0, 32'h0040_0513);

    // Flush and ready together in HOLD: no advance, no count, back to IDLE
    start_fetch(32'h0000_0700, 1, 32'h1111_1111, 1'b0, 32'h0, 32'h0);
    flush = 1'b1; instr_ready = 1'b1;
    #1;
    chk("fr_adv", 32'(pc_advance), 0);
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    chk("fr_valid", 32'(instr_valid), 0);
    chk("fr_count", fetch_count, exp_count);
    pc_addr = 32'h0000_0704;
    tick();
    chk("fr_idle_req", 32'(imem_req), 1);
    chk("fr_idle_addr", imem_addr, 32'h0000_0704);

    // Misaligned PC: fault without request, sticky under flush
    reset_dut();
    pc_addr = 32'h0000_0102;
    tick();
    chk("mis_req", 32'(imem_req), 0);
    chk("mis_fault", 32'(fetch_fault), 1);
    flush = 1'b1; pc_addr = 32'h0000_0104;
    tick(); tick();
    chk("mis_sticky", 32'(fetch_fault), 1);
    chk("mis_req2", 32'(imem_req), 0);
    chk("mis_valid", 32'(instr_valid), 0);
    flush = 1'b0;
    reset_dut();

    // Timeout with no ack: request high for exactly TIMEOUT cycles
    begin
      int n;
      n = 0;
      pc_addr = 32'h0000_0500;
      tick();
      while (imem_req === 1'b1 && n < 20) begin
        n++;
        tick();
      end
      chk("to_cycles", 32'(n), 32'd8);
      chk("to_fault", 32'(fetch_fault), 1);
      chk("to_req", 32'(imem_req), 0);
    end

    // Bus error on ack
    reset_dut();
    pc_addr = 32'h0000_0600;
    tick();
    imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'h5555_AAAA;
    tick();
    imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = '0;
    chk("err_fault", 32'(fetch_fault), 1);
    chk("err_valid", 32'(instr_valid), 0);
    chk("err_req", 32'(imem_req), 0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("err_valid2", 32'(instr_valid), 0);

    // Counter wrap from all ones
    reset_dut();
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    #1;
    chk("wrap_preload", fetch_count, 32'hFFFF_FFFF);
    exp_count = 32'hFFFF_FFFF;
    start_fetch(32'h0000_0800, 0, 32'h0000_0073, 1'b1, 32'h0000_0073, 32'h0000_0800);
    deliver(0, 32'h0000_0073);
    chk("wrap_zero", fetch_count, 32'h0000_0000);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
